bus_arbiter: RTL
================

BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 16: number of ISSUE cycles without bus_ack before the transaction is aborted.
REQ-002 SHALL have parameter ERR_RDATA, default 32'hDEAD_BEEF: read data returned on timeout.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  synchronous active-low reset.
REQ-005 reqN_valid  input  1  (N=0,1) requester N has a pending access; requester 0 is the CPU M-stage port, requester 1 is the DMA/debug port.
REQ-006 reqN_addr  input  32  byte address.
REQ-007 reqN_we  input  1  1 = write, 0 = read.
REQ-008 reqN_mode  input  3  access width/sign mode, same encoding as dm_mode.
REQ-009 reqN_wdata  input  32  write data.
REQ-010 reqN_ready  output  1  one-cycle completion pulse to requester N.
REQ-011 reqN_rdata  output  32  registered read data, valid while reqN_ready is high.
REQ-012 reqN_err  output  1  timeout flag, valid while reqN_ready is high.
REQ-013 bus_valid  output  1  transaction active on the shared device bus.
REQ-014 bus_addr, bus_we, bus_mode, bus_wdata  output  32/1/3/32  latched payload of the granted requester.
REQ-015 bus_ack  input  1  device completes the current transaction.
REQ-016 bus_rdata  input  32  device read data, sampled when bus_ack is high.

Function
REQ-017 FSM states: IDLE, ISSUE, RESP; only these transitions are permitted: IDLE->ISSUE, ISSUE->RESP, RESP->IDLE.
REQ-018 IDLE: if any reqN_valid is high, grant one, latch its addr/we/mode/wdata into the bus registers, clear the timeout counter, and go to ISSUE on the next edge; otherwise stay in IDLE.
REQ-019 Arbitration: single valid requester wins; if both are valid, the requester not granted last wins (round-robin); last_grant updates on the RESP->IDLE transition.
REQ-020 bus_valid SHALL be high exactly in ISSUE; bus_* payload is stable throughout ISSUE.
REQ-021 ISSUE: bus_ack high -> capture bus_rdata, err=0, go to RESP.
REQ-022 ISSUE without bus_ack: counter increments; when the counter equals TIMEOUT_CYCLES-1 and there is no ack, capture ERR_RDATA, err=1, go to RESP; counter width is $clog2(TIMEOUT_CYCLES+1).
REQ-023 RESP: reqN_ready is high for exactly one cycle, only for the granted N; the other ready stays low.
REQ-024 reqN_rdata/reqN_err hold their value until the next RESP for that N.
REQ-025 Latency: valid first high in IDLE cycle k and ack in cycle k+1 -> ready in cycle k+2; back-to-back accesses are separated by at least one IDLE cycle.
REQ-026 bus_ack in IDLE or RESP SHALL be ignored.
REQ-027 Requesters hold valid and payload until ready; if valid drops mid-transaction, the transaction still completes and the ready pulse is still issued.
REQ-028 For writes, reqN_rdata is the captured bus_rdata (don't-care for the requester); err semantics are identical to reads.

Reset
REQ-029 When rst is low at a clock edge: state=IDLE, counter=0, last_grant=1 (so req0 wins the first tie), bus_valid=0, bus_addr=0, bus_we=0, bus_mode=0, bus_wdata=0, reqN_ready=0, reqN_rdata=0, reqN_err=0.
REQ-030 Reset during ISSUE or RESP abandons the transaction; no ready pulse is produced for it.

Structure
REQ-031 State encodings, the TIMEOUT_CYCLES default and the ERR_RDATA default SHALL live in the shared CPU header/package.
REQ-032 The two-way round-robin picker SHALL be a separate sub-module, rr_arb2 (inputs valid[1:0] and last; output grant index), combinational.
REQ-033 The arbiter is inserted between the CPU bus port and the device bridge; the CPU stall logic consumes req0_ready.

Verification
REQ-034 req0 read addr 32'h7F00, bus_ack in the first ISSUE cycle with rdata 32'h1234 -> req0_ready high at k+2 with rdata 32'h1234 and err 0.
REQ-035 req0 and req1 valid in the same cycle after reset -> req0 served first, then req1; a repeated tie is then won by req0 again only after req1 has been served.
REQ-036 req1 write with no bus_ack at all -> bus_valid high for exactly 16 cycles, then req1_ready with err 1 and rdata 32'hDEAD_BEEF.
REQ-037 rst low in the second ISSUE cycle -> bus_valid 0 and state IDLE on the next edge, no ready pulse, and a following tie goes to req0.
REQ-038 bus_ack pulsed in IDLE and in RESP -> no state change and no extra ready pulse; req0 valid dropped mid-ISSUE -> ready pulse still issued.

Source files
------------

// File: rtl/bus_arbiter_pkg.sv
// Shared definitions for the two-requester device bus arbiter:
// FSM encodings, timeout/error defaults and the latched bus payload.
`timescale 1ns/1ps
package bus_arbiter_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_RESP  = 2'd2;

  localparam int          TIMEOUT_CYCLES_DEFAULT = 16;
  localparam logic [31:0] ERR_RDATA_DEFAULT      = 32'hDEAD_BEEF;

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [2:0]  mode;
    logic [31:0] wdata;
  } bus_req_t;

endpackage

// File: rtl/bus_arbiter_rr_arb2.sv
// Two-way round-robin picker: a lone requester wins, a tie goes to the
// requester that was not granted last.
`timescale 1ns/1ps
module rr_arb2 (
  input  logic [1:0] valid,
  input  logic       last,
  output logic       grant
);

  assign grant = (valid == 2'b11) ? ~last : valid[1];

endmodule

// File: rtl/bus_arbiter.sv
// Arbitrates the CPU port (req0) and the DMA/debug port (req1) onto one
// device bus with an IDLE -> ISSUE -> RESP handshake and an ack timeout.
`timescale 1ns/1ps
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int          TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT,
  parameter logic [31:0] ERR_RDATA      = ERR_RDATA_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  input  logic [31:0] req0_addr,
  input  logic        req0_we,
  input  logic [2:0]  req0_mode,
  input  logic [31:0] req0_wdata,
  output logic        req0_ready,
  output logic [31:0] req0_rdata,
  output logic        req0_err,
  input  logic        req1_valid,
  input  logic [31:0] req1_addr,
  input  logic        req1_we,
  input  logic [2:0]  req1_mode,
  input  logic [31:0] req1_wdata,
  output logic        req1_ready,
  output logic [31:0] req1_rdata,
  output logic        req1_err,
  output logic        bus_valid,
  output logic [31:0] bus_addr,
  output logic        bus_we,
  output logic [2:0]  bus_mode,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

  localparam int            CW       = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  bus_req_t [1:0]        req;
  logic [1:0]            state_q, state_d;
  bus_req_t              bus_q, bus_d;
  logic                  grant_q, grant_d;
  logic                  last_q, last_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [1:0][31:0]      rdata_q, rdata_d;
  logic [1:0]            err_q, err_d;
  logic                  pick;

  assign req[0] = '{addr: req0_addr, we: req0_we, mode: req0_mode, wdata: req0_wdata};
  assign req[1] = '{addr: req1_addr, we: req1_we, mode: req1_mode, wdata: req1_wdata};

  rr_arb2 u_rr (
    .valid ({req1_valid, req0_valid}),
    .last  (last_q),
    .grant (pick)
  );

  always_comb begin
    state_d = state_q;
    bus_d   = bus_q;
    grant_d = grant_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (req0_valid || req1_valid) begin
          grant_d = pick;
          bus_d   = req[pick];
          cnt_d   = '0;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (bus_ack) begin
          rdata_d[grant_q] = bus_rdata;
          err_d[grant_q]   = 1'b0;
          state_d          = ST_RESP;
        end else if (cnt_q == CNT_LAST) begin
          rdata_d[grant_q] = ERR_RDATA;
          err_d[grant_q]   = 1'b1;
          state_d          = ST_RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_RESP: begin
        // Round-robin history only advances once the response is delivered.
        last_d  = grant_q;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      bus_q   <= '0;
      grant_q <= 1'b0;
      last_q  <= 1'b1;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      bus_q   <= bus_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign bus_valid  = (state_q == ST_ISSUE);
  assign bus_addr   = bus_q.addr;
  assign bus_we     = bus_q.we;
  assign bus_mode   = bus_q.mode;
  assign bus_wdata  = bus_q.wdata;

  assign req0_ready = (state_q == ST_RESP) && !grant_q;
  assign req1_ready = (state_q == ST_RESP) &&  grant_q;
  assign req0_rdata = rdata_q[0];
  assign req1_rdata = rdata_q[1];
  assign req0_err   = err_q[0];
  assign req1_err   = err_q[1];

endmodule
